// File: rtl/read_addr_arbiter.sv
// Two-master, five-slave AXI read-address arbiter. Grants one master at a time
// (round-robin), forwards its AR request to the decoded slave, and holds the
// read-data route code until the granted master sees its RLAST handshake.
module read_addr_arbiter (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic [3:0]  ARID_M0,
  input  logic [31:0] ARADDR_M0,
  input  logic [3:0]  ARLEN_M0,
  input  logic [2:0]  ARSIZE_M0,
  input  logic [1:0]  ARBURST_M0,
  input  logic        ARVALID_M0,
  output logic        ARREADY_M0,
  input  logic [3:0]  ARID_M1,
  input  logic [31:0] ARADDR_M1,
  input  logic [3:0]  ARLEN_M1,
  input  logic [2:0]  ARSIZE_M1,
  input  logic [1:0]  ARBURST_M1,
  input  logic        ARVALID_M1,
  output logic        ARREADY_M1,
  output logic [7:0]  ARID_S0,
  output logic [31:0] ARADDR_S0,
  output logic [3:0]  ARLEN_S0,
  output logic [2:0]  ARSIZE_S0,
  output logic [1:0]  ARBURST_S0,
  output logic        ARVALID_S0,
  input  logic        ARREADY_S0,
  output logic [7:0]  ARID_S1,
  output logic [31:0] ARADDR_S1,
  output logic [3:0]  ARLEN_S1,
  output logic [2:0]  ARSIZE_S1,
  output logic [1:0]  ARBURST_S1,
  output logic        ARVALID_S1,
  input  logic        ARREADY_S1,
  output logic [7:0]  ARID_S2,
  output logic [31:0] ARADDR_S2,
  output logic [3:0]  ARLEN_S2,
  output logic [2:0]  ARSIZE_S2,
  output logic [1:0]  ARBURST_S2,
  output logic        ARVALID_S2,
  input  logic        ARREADY_S2,
  output logic [7:0]  ARID_S3,
  output logic [31:0] ARADDR_S3,
  output logic [3:0]  ARLEN_S3,
  output logic [2:0]  ARSIZE_S3,
  output logic [1:0]  ARBURST_S3,
  output logic        ARVALID_S3,
  input  logic        ARREADY_S3,
  output logic [7:0]  ARID_S4,
  output logic [31:0] ARADDR_S4,
  output logic [3:0]  ARLEN_S4,
  output logic [2:0]  ARSIZE_S4,
  output logic [1:0]  ARBURST_S4,
  output logic        ARVALID_S4,
  input  logic        ARREADY_S4,
  input  logic        RVALID_M0,
  input  logic        RREADY_M0,
  input  logic        RLAST_M0,
  input  logic        RVALID_M1,
  input  logic        RREADY_M1,
  input  logic        RLAST_M1,
  output logic [1:0]  Aibiter_Read_State_control,
  output logic [3:0]  Arbiter_ARID_control
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ADDR = 2'd1, ST_DATA = 2'd2} state_t;

  localparam logic [2:0] SLV_DEF  = 3'd5;
  localparam logic [3:0] NO_ROUTE = 4'hF;

  state_t      state;
  logic        ptr;       // master favoured on a simultaneous request
  logic        gnt;       // master owning the current transaction
  logic [3:0]  id_q;
  logic [31:0] addr_q;
  logic [3:0]  len_q;
  logic [2:0]  size_q;
  logic [1:0]  burst_q;
  logic [3:0]  route_q;   // {granted master, slave index or SLV_DEF}

  logic [1:0]  m_valid;
  logic        win;
  logic [4:0]  s_ready;
  logic [4:0]  s_valid;
  logic        addr_ok;
  logic        r_done;
  logic [7:0]  s_id;

  assign m_valid = {ARVALID_M1, ARVALID_M0};
  assign s_ready = {ARREADY_S4, ARREADY_S3, ARREADY_S2, ARREADY_S1, ARREADY_S0};
  assign win     = (m_valid == 2'b11) ? ptr : m_valid[1];
  assign r_done  = gnt ? (RVALID_M1 & RREADY_M1 & RLAST_M1)
                       : (RVALID_M0 & RREADY_M0 & RLAST_M0);
  assign s_id    = {(gnt ? 4'b0010 : 4'b0001), id_q};

  // Slave index of an address; unmapped addresses fall to the default target.
  function automatic logic [2:0] decode(input logic [31:0] a);
    if (a <= 32'h0000_3FFF)                              return 3'd0;
    else if (a[31:16] == 16'h0001)                       return 3'd1;
    else if (a[31:16] == 16'h0002)                       return 3'd2;
    else if (a >= 32'h1000_0000 && a <= 32'h1000_03FF)   return 3'd3;
    else if (a >= 32'h2000_0000 && a <= 32'h201F_FFFF)   return 3'd4;
    else                                                 return SLV_DEF;
  endfunction

  // Address-phase valids and the accept condition for the granted master.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    s_valid = '0;
    addr_ok = 1'b0;
    for (int k = 0; k < 5; k++)
      s_valid[k] = (state == ST_ADDR) && (route_q[2:0] == 3'(k));
    if (state == ST_ADDR)
      addr_ok = (route_q[2:0] == SLV_DEF) || |(s_valid & s_ready);
  end

  assign ARREADY_M0 = addr_ok & ~gnt;
  assign ARREADY_M1 = addr_ok &  gnt;

  assign ARVALID_S0 = s_valid[0];
  assign ARVALID_S1 = s_valid[1];
  assign ARVALID_S2 = s_valid[2];
  assign ARVALID_S3 = s_valid[3];
  assign ARVALID_S4 = s_valid[4];

  // Payload is only presented to the slave being addressed, zero elsewhere.
  assign ARID_S0    = s_valid[0] ? s_id    : '0;
  assign ARADDR_S0  = s_valid[0] ? addr_q  : '0;
  assign ARLEN_S0   = s_valid[0] ? len_q   : '0;
  assign ARSIZE_S0  = s_valid[0] ? size_q  : '0;
  assign ARBURST_S0 = s_valid[0] ? burst_q : '0;
  assign ARID_S1    = s_valid[1] ? s_id    : '0;
  assign ARADDR_S1  = s_valid[1] ? addr_q  : '0;
  assign ARLEN_S1   = s_valid[1] ? len_q   : '0;
  assign ARSIZE_S1  = s_valid[1] ? size_q  : '0;
  assign ARBURST_S1 = s_valid[1] ? burst_q : '0;
  assign ARID_S2    = s_valid[2] ? s_id    : '0;
  assign ARADDR_S2  = s_valid[2] ? addr_q  : '0;
  assign ARLEN_S2   = s_valid[2] ? len_q   : '0;
  assign ARSIZE_S2  = s_valid[2] ? size_q  : '0;
  assign ARBURST_S2 = s_valid[2] ? burst_q : '0;
  assign ARID_S3    = s_valid[3] ? s_id    : '0;
  assign ARADDR_S3  = s_valid[3] ? addr_q  : '0;
  assign ARLEN_S3   = s_valid[3] ? len_q   : '0;
  assign ARSIZE_S3  = s_valid[3] ? size_q  : '0;
  assign ARBURST_S3 = s_valid[3] ? burst_q : '0;
  assign ARID_S4    = s_valid[4] ? s_id    : '0;
  assign ARADDR_S4  = s_valid[4] ? addr_q  : '0;
  assign ARLEN_S4   = s_valid[4] ? len_q   : '0;
  assign ARSIZE_S4  = s_valid[4] ? size_q  : '0;
  assign ARBURST_S4 = s_valid[4] ? burst_q : '0;

  assign Aibiter_Read_State_control = state;
  assign Arbiter_ARID_control       = route_q;

  // Arbitration FSM: grant and latch in IDLE, forward in ADDR, wait for RLAST in DATA.
  always_ff @(posedge ACLK) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!ARESETn) begin
      // Payload registers are cleared too, so nothing stale survives a reset.
      state   <= ST_IDLE;
      ptr     <= 1'b0;
      gnt     <= 1'b0;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      route_q <= NO_ROUTE;
    end else begin
      case (state)
        ST_IDLE: if (|m_valid) begin
          gnt     <= win;
          ptr     <= ~win;
          id_q    <= win ? ARID_M1    : ARID_M0;
          addr_q  <= win ? ARADDR_M1  : ARADDR_M0;
          len_q   <= win ? ARLEN_M1   : ARLEN_M0;
          size_q  <= win ? ARSIZE_M1  : ARSIZE_M0;
          burst_q <= win ? ARBURST_M1 : ARBURST_M0;
          route_q <= {win, decode(win ? ARADDR_M1 : ARADDR_M0)};
          state   <= ST_ADDR;
        end
        ST_ADDR: if (addr_ok) state <= ST_DATA;
        ST_DATA: if (r_done) begin
          state   <= ST_IDLE;
          route_q <= NO_ROUTE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_read_addr_arbiter.sv
// Self-checking bench for read_addr_arbiter: directed vector table, a few
// hand-written multi-cycle sequences, and randomized transactions checked
// against an address-map / round-robin reference model.
module tb_read_addr_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [3:0]  m_id    [2];
  logic [31:0] m_addr  [2];
  logic [3:0]  m_len   [2];
  logic [2:0]  m_size  [2];
  logic [1:0]  m_burst [2];
  logic [1:0]  m_valid;
  wire  [1:0]  m_ready;
  logic [4:0]  s_ready;
  wire  [4:0]  s_valid;
  wire  [7:0]  s_id    [5];
  wire  [31:0] s_addr  [5];
  wire  [3:0]  s_len   [5];
  wire  [2:0]  s_size  [5];
  wire  [1:0]  s_burst [5];
  logic [1:0]  r_valid, r_ready, r_last;
  wire  [1:0]  st;
  wire  [3:0]  ctrl;

  int n_cmp  = 0;
  int n_fail = 0;
  logic fav;  // model: master favoured on a tie

  logic [31:0] lo [5] = '{32'h0000_0000, 32'h0001_0000, 32'h0002_0000, 32'h1000_0000, 32'h2000_0000};
  logic [31:0] hi [5] = '{32'h0000_3FFF, 32'h0001_FFFF, 32'h0002_FFFF, 32'h1000_03FF, 32'h201F_FFFF};

  always #5 ACLK = ~ACLK;

  read_addr_arbiter dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARID_M0(m_id[0]), .ARADDR_M0(m_addr[0]), .ARLEN_M0(m_len[0]), .ARSIZE_M0(m_size[0]),
    .ARBURST_M0(m_burst[0]), .ARVALID_M0(m_valid[0]), .ARREADY_M0(m_ready[0]),
    .ARID_M1(m_id[1]), .ARADDR_M1(m_addr[1]), .ARLEN_M1(m_len[1]), .ARSIZE_M1(m_size[1]),
    .ARBURST_M1(m_burst[1]), .ARVALID_M1(m_valid[1]), .ARREADY_M1(m_ready[1]),
    .ARID_S0(s_id[0]), .ARADDR_S0(s_addr[0]), .ARLEN_S0(s_len[0]), .ARSIZE_S0(s_size[0]),
    .ARBURST_S0(s_burst[0]), .ARVALID_S0(s_valid[0]), .ARREADY_S0(s_ready[0]),
    .ARID_S1(s_id[1]), .ARADDR_S1(s_addr[1]), .ARLEN_S1(s_len[1]), .ARSIZE_S1(s_size[1]),
    .ARBURST_S1(s_burst[1]), .ARVALID_S1(s_valid[1]), .ARREADY_S1(s_ready[1]),
    .ARID_S2(s_id[2]), .ARADDR_S2(s_addr[2]), .ARLEN_S2(s_len[2]), .ARSIZE_S2(s_size[2]),
    .ARBURST_S2(s_burst[2]), .ARVALID_S2(s_valid[2]), .ARREADY_S2(s_ready[2]),
    .ARID_S3(s_id[3]), .ARADDR_S3(s_addr[3]), .ARLEN_S3(s_len[3]), .ARSIZE_S3(s_size[3]),
    .ARBURST_S3(s_burst[3]), .ARVALID_S3(s_valid[3]), .ARREADY_S3(s_ready[3]),
    .ARID_S4(s_id[4]), .ARADDR_S4(s_addr[4]), .ARLEN_S4(s_len[4]), .ARSIZE_S4(s_size[4]),
    .ARBURST_S4(s_burst[4]), .ARVALID_S4(s_valid[4]), .ARREADY_S4(s_ready[4]),
    .RVALID_M0(r_valid[0]), .RREADY_M0(r_ready[0]), .RLAST_M0(r_last[0]),
    .RVALID_M1(r_valid[1]), .RREADY_M1(r_ready[1]), .RLAST_M1(r_last[1]),
    .Aibiter_Read_State_control(st), .Arbiter_ARID_control(ctrl)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [48:0] pay(input int k);
    return {s_id[k], s_addr[k], s_len[k], s_size[k], s_burst[k]};
  endfunction

  // OR of all slave payloads except slave 'sel' (sel >= 5 means all of them).
  function automatic logic [48:0] other_pay(input int sel);
    logic [48:0] acc = '0;
    for (int k = 0; k < 5; k++) if (k != sel) acc |= pay(k);
    return acc;
  endfunction

  // Reference route: first address window containing 'a', else default (5);
  // master 1 routes are offset by 8.
  function automatic logic [3:0] ref_route(input logic m, input logic [31:0] a);
    int t = 5;
    for (int k = 4; k >= 0; k--) if (a >= lo[k] && a <= hi[k]) t = k;
    return 4'((m ? 8 : 0) + t);
  endfunction

  // Round-robin model: tie goes to the favoured master, then the other is favoured.
  task automatic pick(output logic w);
    w   = (m_valid == 2'b11) ? fav : m_valid[1];
    fav = ~w;
  endtask

  task automatic new_payload(input int m);
    int sel, k;
    sel = $urandom_range(0, 7);
    k   = $urandom_range(0, 4);
    m_id[m]    = 4'($urandom);
    m_len[m]   = 4'($urandom_range(0, 3));
    m_size[m]  = 3'($urandom);
    m_burst[m] = 2'($urandom);
    if (sel < 5)       m_addr[m] = lo[sel] + $urandom_range(0, hi[sel] - lo[sel]);
    else if (sel == 5) m_addr[m] = hi[k] + 32'd1;
    else if (sel == 6) m_addr[m] = lo[k];
    else               m_addr[m] = $urandom;
  endtask

  // One full transaction. Entry/exit: #1 after a rising edge with the DUT in IDLE.
  task automatic run_txn(input logic w, input logic [3:0] route, input int delay, input bit intrude);
    logic [2:0]  sl;
    bit          dflt, acc;
    logic [48:0] exp_pay;
    int          cyc, beats;
    sl      = route[2:0];
    dflt    = (sl == 3'd5);
    exp_pay = {(w ? 4'b0010 : 4'b0001), m_id[w], m_addr[w], m_len[w], m_size[w], m_burst[w]};
    beats   = int'(m_len[w]) + 1;

    @(negedge ACLK);
    check("idle_state", st, 0);
    check("idle_ctrl", ctrl, 4'hF);
    check("idle_arready_m", m_ready, 0);
    check("idle_arvalid_s", s_valid, 0);
    @(posedge ACLK); #1;

    cyc = 0; acc = 0;
    while (!acc) begin
      if (!dflt && cyc >= delay) s_ready[sl] = 1'b1;
      @(negedge ACLK);
      acc = dflt || (cyc >= delay);
      check("addr_state", st, 1);
      check("addr_ctrl", ctrl, route);
      check("addr_arvalid_s", s_valid, dflt ? 5'b0 : (5'b1 << sl));
      if (!dflt) check("addr_payload", pay(int'(sl)), exp_pay);
      check("addr_other_payload", other_pay(dflt ? 7 : int'(sl)), 0);
      check("addr_arready_m", m_ready, acc ? (2'b01 << w) : 2'b00);
      @(posedge ACLK); #1;
      cyc++;
    end
    s_ready    = '0;
    m_valid[w] = 1'b0;
    if (intrude) m_valid[!w] = 1'b1;

    for (int b = 0; b < beats; b++) begin
      if ($urandom_range(0, 2) == 0) begin
        // stall cycle: RLAST may be up but the handshake is incomplete
        if ($urandom_range(0, 1) != 0) begin r_valid[w] = 1'b0; r_ready[w] = 1'b1; end
        else                           begin r_valid[w] = 1'b1; r_ready[w] = 1'b0; end
        r_last[w] = (b == beats - 1);
        r_valid[!w] = 1'($urandom); r_ready[!w] = 1'($urandom); r_last[!w] = 1'($urandom);
        @(negedge ACLK);
        check("data_stall_state", st, 2);
        @(posedge ACLK); #1;
      end
      r_valid[w] = 1'b1; r_ready[w] = 1'b1; r_last[w] = (b == beats - 1);
      r_valid[!w] = 1'($urandom); r_ready[!w] = 1'($urandom); r_last[!w] = 1'($urandom);
      @(negedge ACLK);
      check("data_state", st, 2);
      check("data_ctrl", ctrl, route);
      check("data_arvalid_s", s_valid, 0);
      check("data_arready_m", m_ready, 0);
      @(posedge ACLK); #1;
    end
    r_valid = '0; r_ready = '0; r_last = '0;
    check("end_state", st, 0);
    check("end_ctrl", ctrl, 4'hF);
  endtask

  typedef struct {
    logic        m;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    int          delay;
    logic [3:0]  route;
    bit          intrude;
  } vec_t;

  vec_t tbl [16];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic w;
    tbl[0]  = '{1'b0, 4'h3, 32'h0001_0040, 4'd0, 0, 4'd1,  1'b0};
    tbl[1]  = '{1'b1, 4'h5, 32'h3000_0000, 4'd0, 0, 4'd13, 1'b0};
    tbl[2]  = '{1'b1, 4'h7, 32'h2000_0100, 4'd1, 5, 4'd12, 1'b0};
    tbl[3]  = '{1'b0, 4'h1, 32'h0000_3FFF, 4'd3, 1, 4'd0,  1'b1};
    tbl[4]  = '{1'b1, 4'h2, 32'h0000_4000, 4'd0, 0, 4'd13, 1'b0};
    tbl[5]  = '{1'b0, 4'h4, 32'h0001_FFFF, 4'd0, 2, 4'd1,  1'b0};
    tbl[6]  = '{1'b1, 4'h6, 32'h0002_0000, 4'd2, 0, 4'd10, 1'b0};
    tbl[7]  = '{1'b0, 4'h8, 32'h0002_FFFF, 4'd0, 0, 4'd2,  1'b0};
    tbl[8]  = '{1'b1, 4'h9, 32'h0003_0000, 4'd0, 0, 4'd13, 1'b0};
    tbl[9]  = '{1'b0, 4'hA, 32'h1000_0000, 4'd1, 3, 4'd3,  1'b0};
    tbl[10] = '{1'b1, 4'hB, 32'h1000_03FF, 4'd0, 0, 4'd11, 1'b0};
    tbl[11] = '{1'b0, 4'hC, 32'h1000_0400, 4'd0, 0, 4'd5,  1'b0};
    tbl[12] = '{1'b1, 4'hD, 32'h201F_FFFF, 4'd0, 1, 4'd12, 1'b0};
    tbl[13] = '{1'b0, 4'hE, 32'h2020_0000, 4'd0, 0, 4'd5,  1'b0};
    tbl[14] = '{1'b1, 4'hF, 32'h0000_0000, 4'd0, 0, 4'd8,  1'b0};
    tbl[15] = '{1'b0, 4'h0, 32'hFFFF_FFFF, 4'd0, 0, 4'd5,  1'b0};

    // Reset with both masters requesting: nothing may be granted.
    ARESETn = 1'b0; s_ready = '0; r_valid = '0; r_ready = '0; r_last = '0;
    for (int m = 0; m < 2; m++) begin
      m_id[m] = 4'h0; m_addr[m] = 32'h0001_0000; m_len[m] = '0; m_size[m] = '0; m_burst[m] = '0;
    end
    m_valid = 2'b11;
    fav = 1'b0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check("rst_state", st, 0);
    check("rst_ctrl", ctrl, 4'hF);
    check("rst_arvalid_s", s_valid, 0);
    check("rst_arready_m", m_ready, 0);
    check("rst_payload", other_pay(7), 0);

    // Simultaneous requests after reset: M0 first, then the pending M1.
    @(posedge ACLK); #1;
    m_valid = 2'b00;
    m_addr[0] = 32'h0002_0010; m_id[0] = 4'h6; m_len[0] = 4'd1; m_size[0] = 3'd2; m_burst[0] = 2'd1;
    m_addr[1] = 32'h1000_0004; m_id[1] = 4'h2; m_len[1] = 4'd0; m_size[1] = 3'd1; m_burst[1] = 2'd2;
    m_valid = 2'b11;
    ARESETn = 1'b1;
    pick(w); run_txn(w, 4'd2, 0, 1'b0);
    pick(w); run_txn(w, 4'd11, 1, 1'b0);

    // Directed vector table: address-map boundaries, default target, delays, bursts.
    for (int i = 0; i < 16; i++) begin
      m_valid = 2'b00;
      m_id[tbl[i].m]    = tbl[i].id;
      m_addr[tbl[i].m]  = tbl[i].addr;
      m_len[tbl[i].m]   = tbl[i].len;
      m_size[tbl[i].m]  = 3'($urandom);
      m_burst[tbl[i].m] = 2'($urandom);
      m_valid[tbl[i].m] = 1'b1;
      pick(w);
      run_txn(w, tbl[i].route, tbl[i].delay, tbl[i].intrude);
    end

    // Randomized traffic against the reference model.
    m_valid = 2'b00;
    for (int i = 0; i < 40; i++) begin
      for (int m = 0; m < 2; m++)
        if (!m_valid[m] && $urandom_range(0, 1) != 0) begin new_payload(m); m_valid[m] = 1'b1; end
      if (m_valid == 2'b00) begin new_payload(0); m_valid[0] = 1'b1; end
      pick(w);
      run_txn(w, ref_route(w, m_addr[w]), $urandom_range(0, 3), 1'($urandom));
    end

    // Reset in the middle of DATA, then the pointer must favour M0 again.
    m_valid = 2'b01;
    m_addr[0] = 32'h0002_0100; m_id[0] = 4'h9; m_len[0] = 4'd2; m_size[0] = 3'd3; m_burst[0] = 2'd1;
    @(posedge ACLK); #1;
    check("midrst_addr_state", st, 1);
    s_ready[2] = 1'b1;
    @(posedge ACLK); #1;
    s_ready = '0;
    m_valid = 2'b11;
    check("midrst_data_state", st, 2);
    ARESETn = 1'b0;
    @(posedge ACLK); #1;
    check("midrst_state", st, 0);
    check("midrst_ctrl", ctrl, 4'hF);
    check("midrst_arvalid_s", s_valid, 0);
    check("midrst_arready_m", m_ready, 0);
    ARESETn = 1'b1;
    fav = 1'b0;
    pick(w);
    run_txn(w, ref_route(w, m_addr[w]), 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/read_addr_arbiter.md
READ_ADDR_ARBITER -- requirements
Module: read_addr_arbiter

Interface
REQ-001 SHALL have ACLK, input, 1 bit: the single clock, rising-edge.
REQ-002 SHALL have ARESETn, input, 1 bit: synchronous, active-low reset, sampled on the ACLK rising edge.
REQ-003 SHALL have ARID_Mm [3:0], ARADDR_Mm [31:0], ARLEN_Mm [3:0], ARSIZE_Mm [2:0], ARBURST_Mm [1:0], ARVALID_Mm, all inputs, for m=0,1: master AR requests.
REQ-004 SHALL have ARREADY_Mm, output, 1 bit, m=0,1: AR accept to each master.
REQ-005 SHALL have ARID_Sk [7:0], ARADDR_Sk [31:0], ARLEN_Sk [3:0], ARSIZE_Sk [2:0], ARBURST_Sk [1:0], ARVALID_Sk, all outputs, for k=0..4: slave AR ports.
REQ-006 SHALL have ARREADY_Sk, input, 1 bit, k=0..4.
REQ-007 SHALL have RVALID_Mm, RREADY_Mm, RLAST_Mm, all inputs, 1 bit, m=0,1: taps of the master-side R channel.
REQ-008 SHALL have Aibiter_Read_State_control, output, 2 bits: FSM state, IDLE=0, ADDR=1, DATA=2.
REQ-009 SHALL have Arbiter_ARID_control, output, 4 bits: route code for the read data mux.
  - M0_Sk = k; M0_default = 5.
  - M1_Sk = 8+k; M1_default = 13.
  - No route = 4'hF.

Function
REQ-010 SHALL decode the slave from the latched address:
  - S0: 0x0000_0000-0x0000_3FFF.
  - S1: 0x0001_0000-0x0001_FFFF.
  - S2: 0x0002_0000-0x0002_FFFF.
  - S3: 0x1000_0000-0x1000_03FF.
  - S4: 0x2000_0000-0x201F_FFFF.
  - Anything else: default.
REQ-011 SHALL arbitrate in IDLE only, using round-robin with a 1-bit priority pointer; after reset the pointer favours M0, and after each grant it favours the other master.
REQ-012 SHALL, on a grant, register master index, ARID, ARADDR, ARLEN, ARSIZE and ARBURST, and move to ADDR on the next edge.
REQ-013 SHALL, in ADDR, drive ARVALID_Sk=1 only for the decoded slave, with registered payload and ARID_Sk = {4'b0001 for M0 or 4'b0010 for M1, latched ARID}.
REQ-014 SHALL drive ARREADY_Mm = ARREADY_Sk combinationally for the granted master and decoded slave in ADDR; ARREADY_Mm is 0 otherwise.
REQ-015 SHALL move ADDR -> DATA on the edge where ARVALID_Sk and ARREADY_Sk are both 1.
REQ-016 SHALL, for a default target, assert no ARVALID_Sk, assert ARREADY_Mm for exactly one ADDR cycle, then move to DATA.
REQ-017 SHALL hold Arbiter_ARID_control at the granted route code throughout ADDR and DATA, and at 4'hF in IDLE.
REQ-018 SHALL move DATA -> IDLE on the edge where RVALID_Mm, RREADY_Mm and RLAST_Mm of the granted master are all 1; non-last beats do not change state.
REQ-019 SHALL ignore all ARVALID_M inputs outside IDLE; only one read is outstanding at a time.
REQ-020 SHALL permit re-arbitration in the first IDLE cycle after DATA, giving a minimum of 3 cycles per single-beat transaction.
REQ-021 SHALL, when both masters request in the same IDLE cycle, grant the master selected by the pointer.
REQ-022 SHALL drive all slave payload outputs to 0 whenever the matching ARVALID_Sk is 0.

Reset
REQ-023 SHALL, while ARESETn=0 at an edge, set on that edge:
  - state = IDLE;
  - pointer = M0;
  - all ARVALID_Sk = 0 and ARREADY_Mm = 0;
  - all payload registers = 0;
  - Arbiter_ARID_control = 4'hF; Aibiter_Read_State_control = 0.
REQ-024 SHALL abandon any in-flight transaction on a reset asserted mid-operation, with no further AR output after the reset edge.

Verification
REQ-025 M0 ARADDR=0x0001_0040, ARID=3, S1 ARREADY held 1 -> ARVALID_S1=1 one cycle after the request, ARID_S1=0x13, ARREADY_M0 pulses one cycle, control=1; RLAST handshake -> IDLE, control=4'hF.
REQ-026 M0 and M1 request simultaneously after reset -> M0 granted first (control=k); after M0's RLAST, M1 granted (control=8+k).
REQ-027 M1 ARADDR=0x3000_0000 -> no ARVALID_Sk, ARREADY_M1 high for one cycle, control=13; stays in DATA until the RLAST handshake on M1.
REQ-028 S4 ARREADY delayed 5 cycles -> ARVALID_S4 and payload stable for all 5 cycles; ARREADY_M1 only in the accept cycle.
REQ-029 ARLEN=3 burst -> state DATA across beats 0-2, IDLE only after the beat-3 RLAST handshake; a new ARVALID_M during DATA is not accepted.
REQ-030 ARESETn low during DATA -> next edge state=0, control=4'hF, all ARVALID_Sk=0; the pending M0 request is re-granted after reset release.
